// File: rtl/uart_console_rx.sv
// UART receive front end: 2-flop synchroniser, 8N1 deserialiser, byte FIFO, valid/ack console port.
// Optional even-parity (8E1) framing is enabled by defining UART_RX_PARITY_EN.
module uart_console_rx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          RX,
  output logic [7:0]                    CONSOLE_IN,
  output logic                          CONSOLE_IN_valid,
  input  logic                          CONSOLE_IN_ack,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                          OVERRUN,
  output logic                          FRAME_ERR,
  output logic                          PARITY_ERR,
  input  logic                          CLR_ERR
);
  localparam int CPB  = CLK_FREQ_HZ / BAUD;
  localparam int CNTW = $clog2(CPB);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CPB - 1);
  localparam logic [CNTW-1:0] CNT_MID  = CNTW'(CPB / 2 - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   CW_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_WAIT_IDLE, S_IDLE, S_START, S_DATA, S_STOP
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } rx_state_t;

  rx_state_t       r_state, w_state_nxt;
  logic            r_rx_meta, r_rx_s;
  logic [CNTW-1:0] r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            w_at_bit, w_cnt_clr, w_push, w_ferr_set, w_par_set;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ack_pending, r_overrun, r_frame_err, r_par_err;
  logic            w_full, w_pop, w_wr, w_ovr_set;
`ifdef UART_RX_PARITY_EN
  logic            r_par_bad;
`endif

  // Reset the synchroniser to 0 so a line that is mid-frame at reset release is held in WAIT_IDLE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rx_meta <= 1'b0;
      r_rx_s    <= 1'b0;
    end else begin
      r_rx_meta <= RX;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_at_bit = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;
    w_par_set   = 1'b0;
    case (r_state)
      S_WAIT_IDLE: if (r_rx_s) w_state_nxt = S_IDLE;
      S_IDLE: if (!r_rx_s) begin
        w_state_nxt = S_START;
        w_cnt_clr   = 1'b1;
      end
      S_START: if (r_cnt == CNT_MID) begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (w_at_bit) begin
        w_cnt_clr = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (r_bit == 3'd7) w_state_nxt = S_PARITY;
`else
        if (r_bit == 3'd7) w_state_nxt = S_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (w_at_bit) begin
        w_cnt_clr   = 1'b1;
        w_par_set   = (r_rx_s != ^r_shift);
        w_state_nxt = S_STOP;
      end
`endif
      S_STOP: if (w_at_bit) begin
        w_cnt_clr = 1'b1;
        if (r_rx_s) begin
`ifdef UART_RX_PARITY_EN
          w_push = !r_par_bad;
`else
          w_push = 1'b1;
`endif
          w_state_nxt = S_IDLE;
        end else begin
          w_ferr_set  = 1'b1;
          w_state_nxt = S_WAIT_IDLE;
        end
      end
      default: w_state_nxt = S_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_WAIT_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_clr ? '0 : r_cnt + CNT_ONE;
      if (r_state == S_START) r_bit <= 3'd0;
      if (r_state == S_DATA && w_at_bit) begin
        r_shift <= {r_rx_s, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      if (r_state == S_IDLE) r_par_bad <= 1'b0;
      else if (w_par_set)    r_par_bad <= 1'b1;
`endif
    end
  end

  // Handshake: valid means the head byte is unconsumed; ack while valid pops it, and valid
  // stays low until ack has been seen low again (four-phase), so one ack pops exactly one byte.
  assign w_full    = (r_count == CNT_FULL);
  assign w_pop     = CONSOLE_IN_ack && CONSOLE_IN_valid;
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovr_set = w_push && w_full && !w_pop;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_ack_pending <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_wr && !w_pop)      r_count <= r_count + CW_ONE;
      else if (!w_wr && w_pop) r_count <= r_count - CW_ONE;
      if (w_pop)                r_ack_pending <= 1'b1;
      else if (!CONSOLE_IN_ack) r_ack_pending <= 1'b0;
    end
  end

  // A set event in the same cycle as CLR_ERR wins.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
    end else begin
      if (w_ovr_set)    r_overrun <= 1'b1;
      else if (CLR_ERR) r_overrun <= 1'b0;
      if (w_ferr_set)   r_frame_err <= 1'b1;
      else if (CLR_ERR) r_frame_err <= 1'b0;
      if (w_par_set)    r_par_err <= 1'b1;
      else if (CLR_ERR) r_par_err <= 1'b0;
    end
  end

  assign CONSOLE_IN       = r_mem[r_rd_ptr];
  assign CONSOLE_IN_valid = (r_count != '0) && !r_ack_pending;
  assign FIFO_COUNT       = r_count;
  assign OVERRUN          = r_overrun;
  assign FRAME_ERR        = r_frame_err;
`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR       = r_par_err;
`else
  assign PARITY_ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_console_rx.sv
// Directed bench for uart_console_rx at 10 clocks per bit; expected bytes held in a queue.
// Covers handshake, back-to-back frames, overrun, framing error, glitch and mid-frame reset.
module tb_uart_console_rx;
  localparam int CPB = 10;

  logic       CLK = 1'b0;
  logic       RESET, RX, CONSOLE_IN_ack, CLR_ERR;
  logic [7:0] CONSOLE_IN;
  logic       CONSOLE_IN_valid;
  logic [4:0] FIFO_COUNT;
  logic       OVERRUN, FRAME_ERR, PARITY_ERR;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  uart_console_rx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(16)) dut (
    .CLK(CLK), .RESET(RESET), .RX(RX),
    .CONSOLE_IN(CONSOLE_IN), .CONSOLE_IN_valid(CONSOLE_IN_valid), .CONSOLE_IN_ack(CONSOLE_IN_ack),
    .FIFO_COUNT(FIFO_COUNT), .OVERRUN(OVERRUN), .FRAME_ERR(FRAME_ERR), .PARITY_ERR(PARITY_ERR),
    .CLR_ERR(CLR_ERR)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bits(input logic [11:0] bits, input int nb);
    for (int i = 0; i < nb; i++) begin
      RX = bits[i];
      tick(CPB);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    logic [11:0] b;
    b = 12'h000;
    b[8:1] = d;
`ifdef UART_RX_PARITY_EN
    b[9]  = ^d;
    b[10] = stop_bit;
    send_bits(b, 11);
`else
    b[9] = stop_bit;
    send_bits(b, 10);
`endif
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!CONSOLE_IN_valid && k < 300) begin
      tick(1);
      k++;
    end
    check($sformatf("%s_valid", tag), CONSOLE_IN_valid, 1);
  endtask

  task automatic drain_one(input string tag);
    logic [7:0] e;
    int k;
    wait_valid(tag);
    e = 8'h00;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check($sformatf("%s_data", tag), CONSOLE_IN, e);
    CONSOLE_IN_ack = 1'b1;
    k = 0;
    while (CONSOLE_IN_valid && k < 5) begin
      tick(1);
      k++;
    end
    check($sformatf("%s_drop", tag), CONSOLE_IN_valid, 0);
    CONSOLE_IN_ack = 1'b0;
    tick(1);
  endtask

  initial begin
    RESET = 1'b1; RX = 1'b1; CONSOLE_IN_ack = 1'b0; CLR_ERR = 1'b0;
    tick(3);
    check("rst_count", FIFO_COUNT, 0);
    check("rst_valid", CONSOLE_IN_valid, 0);
    check("rst_data", CONSOLE_IN, 0);
    check("rst_ovr", OVERRUN, 0);
    check("rst_ferr", FRAME_ERR, 0);
    check("rst_perr", PARITY_ERR, 0);
    RESET = 1'b0;
    tick(5);

    // single byte and full four-phase ack
    send_byte(8'h50, 1'b1);
    exp_q.push_back(8'h50);
    tick(2);
    check("t1_count", FIFO_COUNT, 1);
    drain_one("t1");
    check("t1_count0", FIFO_COUNT, 0);
    tick(2);
    check("t1_stays_low", CONSOLE_IN_valid, 0);

    // two back-to-back bytes, valid re-rises only after ack low
    send_byte(8'h41, 1'b1);
    send_byte(8'h0D, 1'b1);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h0D);
    tick(3);
    check("t2_count", FIFO_COUNT, 2);
    check("t2_valid", CONSOLE_IN_valid, 1);
    check("t2_head", CONSOLE_IN, exp_q[0]);
    CONSOLE_IN_ack = 1'b1;
    tick(1);
    void'(exp_q.pop_front());
    check("t2_drop", CONSOLE_IN_valid, 0);
    check("t2_count1", FIFO_COUNT, 1);
    tick(1);
    check("t2_hold_low", CONSOLE_IN_valid, 0);
    CONSOLE_IN_ack = 1'b0;
    tick(1);
    check("t2_rerise", CONSOLE_IN_valid, 1);
    check("t2_head2", CONSOLE_IN, exp_q[0]);
    drain_one("t2b");
    check("t2_empty", FIFO_COUNT, 0);

    // overrun: 17 bytes into a 16-deep FIFO
    for (int i = 1; i <= 17; i++) begin
      send_byte(8'(i), 1'b1);
      if (i <= 16) exp_q.push_back(8'(i));
    end
    tick(3);
    check("t3_count", FIFO_COUNT, 16);
    check("t3_ovr", OVERRUN, 1);
    for (int i = 0; i < 16; i++) drain_one($sformatf("t3_%0d", i));
    check("t3_empty", FIFO_COUNT, 0);
    check("t3_ovr_sticky", OVERRUN, 1);
    CLR_ERR = 1'b1;
    tick(1);
    CLR_ERR = 1'b0;
    check("t3_ovr_clr", OVERRUN, 0);

    // framing error, line held low, then recovery
    send_byte(8'h3C, 1'b0);
    RX = 1'b0;
    tick(30);
    check("t4_ferr", FRAME_ERR, 1);
    check("t4_count", FIFO_COUNT, 0);
    RX = 1'b1;
    tick(5);
    send_byte(8'h55, 1'b1);
    exp_q.push_back(8'h55);
    tick(3);
    check("t4_count1", FIFO_COUNT, 1);
    drain_one("t4");
    check("t4_ferr_sticky", FRAME_ERR, 1);
    CLR_ERR = 1'b1;
    tick(1);
    CLR_ERR = 1'b0;
    check("t4_ferr_clr", FRAME_ERR, 0);

    // short glitch on idle line
    RX = 1'b0;
    tick(3);
    RX = 1'b1;
    tick(30);
    check("t5_glitch_count", FIFO_COUNT, 0);
    check("t5_glitch_valid", CONSOLE_IN_valid, 0);
    check("t5_glitch_ferr", FRAME_ERR, 0);
    check("t5_glitch_ovr", OVERRUN, 0);
    check("t5_glitch_perr", PARITY_ERR, 0);

    // reset in the middle of an all-zero frame
    send_byte(8'h7E, 1'b1);
    tick(3);
    check("t5_pre_valid", CONSOLE_IN_valid, 1);
    RX = 1'b0;
    tick(CPB + 5);
    RESET = 1'b1;
    tick(2);
    check("t5_rst_count", FIFO_COUNT, 0);
    check("t5_rst_valid", CONSOLE_IN_valid, 0);
    check("t5_rst_data", CONSOLE_IN, 0);
    RESET = 1'b0;
`ifdef UART_RX_PARITY_EN
    tick(3 + 8 * CPB);
`else
    tick(3 + 7 * CPB);
`endif
    RX = 1'b1;
    tick(CPB + 5);
    check("t5_rest_ignored", FIFO_COUNT, 0);
    check("t5_rest_ferr", FRAME_ERR, 0);
    send_byte(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    tick(3);
    check("t5_count1", FIFO_COUNT, 1);
    drain_one("t5");

`ifdef UART_RX_PARITY_EN
    // even parity: correct bit pushes, wrong bit flags and drops
    send_bits({1'b1, 1'b0, 8'h41, 1'b0}, 11);
    exp_q.push_back(8'h41);
    tick(3);
    drain_one("t6_good");
    check("t6_good_perr", PARITY_ERR, 0);
    send_bits({1'b1, 1'b1, 8'h41, 1'b0}, 11);
    tick(3);
    check("t6_bad_perr", PARITY_ERR, 1);
    check("t6_bad_count", FIFO_COUNT, 0);
    check("t6_bad_ferr", FRAME_ERR, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
